// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between the execute stage and mul_div_unit
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit with hi/lo registers; MDU_MADD_EN enables MADD/MADDU
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  mul_div_unit_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               is_div, is_madd, neg_hi, neg_lo;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               accept, op_madd, accept_arith, accept_mthi, accept_mtlo;
  logic               op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] acc_step, prod, mul_res;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Decode a request; only an idle unit listens, and flush drops a simultaneous start
  always_comb begin
    accept = (state == IDLE) && bus.start && !bus.flush;
`ifdef MDU_MADD_EN
    op_madd = bus.op[2] & bus.op[1];
`else
    op_madd = 1'b0;
`endif
    accept_arith = accept && (!bus.op[2] || op_madd);
    accept_mthi  = accept && (bus.op == 3'b100);
    accept_mtlo  = accept && (bus.op == 3'b101);
    op_signed    = !bus.op[0];
    a_neg        = op_signed && bus.a[WIDTH-1];
    b_neg        = op_signed && bus.b[WIDTH-1];
    a_mag        = a_neg ? (~bus.a + 1'b1) : bus.a;
    b_mag        = b_neg ? (~bus.b + 1'b1) : bus.b;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: WIDTH iteration cycles, one fix-up cycle, flush aborts from either
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_arith) state_nxt = RUN;
      RUN:     if (bus.flush) state_nxt = IDLE;
               else if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration step and the sign-corrected final result
  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}, shift right each step
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
    // Divide: acc = {remainder, remaining dividend bits / quotient bits}, shift left each step
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, mag_b};
    if (is_div) begin
      if (div_diff[WIDTH]) acc_step = {acc[2*WIDTH-2:0], 1'b0};
      else                 acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
    prod    = neg_lo ? (~acc + 1'b1) : acc;
    mul_res = prod + (is_madd ? {hi_q, lo_q} : {(2*WIDTH){1'b0}});
    if (is_div) begin
      res_lo = neg_lo ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
      res_hi = neg_hi ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end else begin
      res_hi = mul_res[2*WIDTH-1:WIDTH];
      res_lo = mul_res[WIDTH-1:0];
    end
  end

  // Operand capture, iteration, hi/lo writes and the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      is_madd <= 1'b0;
      neg_hi  <= 1'b0;
      neg_lo  <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept_mthi) hi_q <= bus.a;
      if (accept_mtlo) lo_q <= bus.a;
      if (accept_arith) begin
        cnt     <= '0;
        is_div  <= !bus.op[2] && bus.op[1];
        is_madd <= op_madd;
        mag_a   <= a_mag;
        mag_b   <= b_mag;
        // Remainder follows the dividend; a zero divisor keeps the quotient all ones
        neg_hi  <= a_neg;
        neg_lo  <= (a_neg ^ b_neg) && (bus.b != '0 || !bus.op[1] || bus.op[2]);
        acc     <= {{WIDTH{1'b0}}, (!bus.op[2] && bus.op[1]) ? a_mag : b_mag};
      end
      if (state == RUN && !bus.flush) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        acc <= acc_step;
      end
      if (state == FIX && !bus.flush) begin
        hi_q   <= res_hi;
        lo_q   <= res_lo;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
